// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared types and helpers for the programmable synchronous FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

   typedef enum logic {
      FIFO_STD  = 1'b0,
      FIFO_FWFT = 1'b1
   } fifo_mode_e;

   localparam int unsigned c_MIN_DEPTH = 2;

   // Pointer width for a given depth; a depth below the minimum still needs one bit.
   function automatic int unsigned fifo_aw(input int unsigned depth);
      return (depth < c_MIN_DEPTH) ? 1 : $clog2(depth);
   endfunction

   // Explicit wrap so that non-power-of-two depths never index past the array.
   function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
      return (ptr >= depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : fifo_mem
// Description : DEPTH x WIDTH storage, synchronous write, asynchronous read.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_mem #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         r_mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = r_mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/sync_fifo_prog.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_prog
// Description : Single-clock FIFO, any depth, std or FWFT output, programmable
//               almost-full/almost-empty thresholds and sticky error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_prog
   import fifo_pkg::*;
#(
   parameter int FIFO_WIDTH = 16,
   parameter int FIFO_DEPTH = 8,
   parameter int FWFT       = 0,
   localparam int AW        = int'(fifo_aw(FIFO_DEPTH))
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [FIFO_WIDTH-1:0] data_in,
   input  logic                  rd_en,
   input  logic [AW:0]           af_thresh,
   input  logic [AW:0]           ae_thresh,
   input  logic                  err_clr,
   output logic [FIFO_WIDTH-1:0] data_out,
   output logic                  wr_ack,
   output logic                  overflow,
   output logic                  underflow,
   output logic                  full,
   output logic                  empty,
   output logic                  almostfull,
   output logic                  almostempty,
   output logic [AW:0]           level,
   output logic                  ovf_sticky,
   output logic                  udf_sticky
);

   localparam fifo_mode_e  c_MODE  = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
   localparam logic [AW:0] c_DEPTH = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0] c_ONE   = (AW+1)'(1);

   logic [AW-1:0]         r_wr_ptr;
   logic [AW-1:0]         r_rd_ptr;
   logic [AW:0]           r_level;
   logic                  r_wr_ack;
   logic                  r_overflow;
   logic                  r_underflow;
   logic                  r_ovf_sticky;
   logic                  r_udf_sticky;
   logic                  w_wr_acc;
   logic                  w_rd_acc;
   logic                  w_wr_rej;
   logic                  w_rd_rej;
   logic [FIFO_WIDTH-1:0] w_mem_rd;

   // Acceptance is decided on the pre-edge level, so a full FIFO still pops and an empty one still pushes.
   assign w_wr_acc = wr_en && (r_level < c_DEPTH);
   assign w_rd_acc = rd_en && (r_level != '0);
   assign w_wr_rej = wr_en && !w_wr_acc;
   assign w_rd_rej = rd_en && !w_rd_acc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= AW'(ptr_inc(32'(r_wr_ptr), FIFO_DEPTH));
         end
         if (w_rd_acc) begin
            r_rd_ptr <= AW'(ptr_inc(32'(r_rd_ptr), FIFO_DEPTH));
         end
         case ({w_wr_acc, w_rd_acc})
            2'b10:   r_level <= r_level + c_ONE;
            2'b01:   r_level <= r_level - c_ONE;
            default: r_level <= r_level;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ack     <= 1'b0;
         r_overflow   <= 1'b0;
         r_underflow  <= 1'b0;
         r_ovf_sticky <= 1'b0;
         r_udf_sticky <= 1'b0;
      end else begin
         r_wr_ack     <= w_wr_acc;
         r_overflow   <= w_wr_rej;
         r_underflow  <= w_rd_rej;
         // A new error in the same cycle as err_clr keeps the flag set.
         r_ovf_sticky <= w_wr_rej || (r_ovf_sticky && !err_clr);
         r_udf_sticky <= w_rd_rej || (r_udf_sticky && !err_clr);
      end
   end

   fifo_mem #(
      .WIDTH (FIFO_WIDTH),
      .DEPTH (FIFO_DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk     (clk),
      .wr_en   (w_wr_acc),
      .wr_addr (r_wr_ptr),
      .wr_data (data_in),
      .rd_addr (r_rd_ptr),
      .rd_data (w_mem_rd)
   );

   generate
      if (c_MODE == FIFO_FWFT) begin : g_fwft
         assign data_out = w_mem_rd;
      end else begin : g_std
         logic [FIFO_WIDTH-1:0] r_data_out;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_data_out <= '0;
            end else if (w_rd_acc) begin
               r_data_out <= w_mem_rd;
            end
         end

         assign data_out = r_data_out;
      end
   endgenerate

   // Status flags are held low while reset is asserted.
   assign full        = rst_n && (r_level == c_DEPTH);
   assign empty       = rst_n && (r_level == '0);
   assign almostfull  = rst_n && (r_level >= af_thresh);
   assign almostempty = rst_n && (r_level <= ae_thresh);

   assign level      = r_level;
   assign wr_ack     = r_wr_ack;
   assign overflow   = r_overflow;
   assign underflow  = r_underflow;
   assign ovf_sticky = r_ovf_sticky;
   assign udf_sticky = r_udf_sticky;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_prog.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_prog
// Description : Scoreboard bench: standard-mode 16x8 FIFO and FWFT 16x5 FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_prog;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        wr_en, rd_en, err_clr;
   logic [15:0] data_in, data_out;
   logic [3:0]  af_thresh, ae_thresh, level;
   logic        wr_ack, overflow, underflow, full, empty, almostfull, almostempty;
   logic        ovf_sticky, udf_sticky;

   logic        f_wr_en, f_rd_en, f_err_clr;
   logic [15:0] f_data_in, f_data_out;
   logic [3:0]  f_af_thresh, f_ae_thresh, f_level;
   logic        f_wr_ack, f_overflow, f_underflow, f_full, f_empty, f_almostfull, f_almostempty;
   logic        f_ovf_sticky, f_udf_sticky;

   int          vec  = 0;
   int          errs = 0;
   logic [15:0] q[$];
   logic [15:0] fq[$];
   logic [15:0] exp_d;

   sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .FWFT(0)) u_dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
      .af_thresh(af_thresh), .ae_thresh(ae_thresh), .err_clr(err_clr),
      .data_out(data_out), .wr_ack(wr_ack), .overflow(overflow), .underflow(underflow),
      .full(full), .empty(empty), .almostfull(almostfull), .almostempty(almostempty),
      .level(level), .ovf_sticky(ovf_sticky), .udf_sticky(udf_sticky)
   );

   sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(5), .FWFT(1)) u_fwft (
      .clk(clk), .rst_n(rst_n), .wr_en(f_wr_en), .data_in(f_data_in), .rd_en(f_rd_en),
      .af_thresh(f_af_thresh), .ae_thresh(f_ae_thresh), .err_clr(f_err_clr),
      .data_out(f_data_out), .wr_ack(f_wr_ack), .overflow(f_overflow), .underflow(f_underflow),
      .full(f_full), .empty(f_empty), .almostfull(f_almostfull), .almostempty(f_almostempty),
      .level(f_level), .ovf_sticky(f_ovf_sticky), .udf_sticky(f_udf_sticky)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      af_thresh = 4'd0;
      cyc();
      vec++; if ({full, empty, almostfull, almostempty, wr_ack, overflow, underflow, ovf_sticky, udf_sticky} !== 9'b0) begin
         errs++; $display("FAIL reset_flags: got %b want %b", {full, empty, almostfull, almostempty, wr_ack, overflow, underflow, ovf_sticky, udf_sticky}, 9'b0);
      end
      vec++; if (level !== 4'd0 || data_out !== 16'h0) begin
         errs++; $display("FAIL reset_level_data: got level=%0d data=%h want 0/0000", level, data_out);
      end
      @(negedge clk);
      rst_n = 1'b1;
      cyc();
      vec++; if ({empty, almostempty, almostfull, full, f_empty} !== 5'b11101 || level !== 4'd0) begin
         errs++; $display("FAIL post_reset: got e/ae/af/f/fe=%b level=%0d want 11101 level=0", {empty, almostempty, almostfull, full, f_empty}, level);
      end
      af_thresh = 4'd8;
   endtask

   task automatic test_fill_drain();
      for (int i = 0; i < 8; i++) begin
         wr_en = 1'b1; data_in = 16'(16'h1000 + i); q.push_back(data_in);
         cyc();
         vec++; if (wr_ack !== 1'b1 || level !== 4'(i + 1)) begin
            errs++; $display("FAIL fill_%0d: got ack=%b level=%0d want 1/%0d", i, wr_ack, level, i + 1);
         end
      end
      wr_en = 1'b0;
      vec++; if (full !== 1'b1) begin errs++; $display("FAIL fill_full: got %b want 1", full); end
      for (int i = 0; i < 8; i++) begin
         rd_en = 1'b1;
         cyc();
         exp_d = q.pop_front();
         vec++; if (data_out !== exp_d) begin errs++; $display("FAIL drain_%0d: got %h want %h", i, data_out, exp_d); end
      end
      rd_en = 1'b0;
      vec++; if (empty !== 1'b1 || level !== 4'd0 || wr_ack !== 1'b0) begin
         errs++; $display("FAIL drain_empty: got empty=%b level=%0d ack=%b want 1/0/0", empty, level, wr_ack);
      end
   endtask

   task automatic test_ovf_udf();
      int ovf_cnt = 0;
      for (int i = 0; i < 9; i++) begin
         wr_en = 1'b1; data_in = 16'(16'h2000 + i);
         if (i < 8) q.push_back(data_in);
         cyc();
         if (overflow) ovf_cnt++;
         vec++; if (overflow !== (i == 8)) begin errs++; $display("FAIL ovf_pulse_%0d: got %b want %b", i, overflow, (i == 8)); end
      end
      wr_en = 1'b0;
      cyc();
      if (overflow) ovf_cnt++;
      vec++; if (ovf_cnt != 1 || ovf_sticky !== 1'b1) begin
         errs++; $display("FAIL ovf_count: got pulses=%0d sticky=%b want 1/1", ovf_cnt, ovf_sticky);
      end
      for (int i = 0; i < 9; i++) begin
         rd_en = 1'b1;
         cyc();
         if (i < 8) begin
            exp_d = q.pop_front();
            vec++; if (data_out !== exp_d || underflow !== 1'b0) begin
               errs++; $display("FAIL udf_read_%0d: got %h udf=%b want %h/0", i, data_out, underflow, exp_d);
            end
         end else begin
            vec++; if (underflow !== 1'b1 || data_out !== 16'h2007 || udf_sticky !== 1'b1) begin
               errs++; $display("FAIL udf_pulse: got udf=%b data=%h sticky=%b want 1/2007/1", underflow, data_out, udf_sticky);
            end
         end
      end
      rd_en = 1'b0;
      cyc();
      vec++; if (underflow !== 1'b0 || udf_sticky !== 1'b1 || ovf_sticky !== 1'b1) begin
         errs++; $display("FAIL sticky_hold: got udf=%b us=%b os=%b want 0/1/1", underflow, udf_sticky, ovf_sticky);
      end
      err_clr = 1'b1;
      cyc();
      err_clr = 1'b0;
      vec++; if (udf_sticky !== 1'b0 || ovf_sticky !== 1'b0) begin
         errs++; $display("FAIL sticky_clr: got us=%b os=%b want 0/0", udf_sticky, ovf_sticky);
      end
   endtask

   task automatic test_simultaneous();
      for (int i = 0; i < 8; i++) begin
         wr_en = 1'b1; data_in = 16'(16'h3000 + i); q.push_back(data_in);
         cyc();
      end
      rd_en = 1'b1; data_in = 16'hDEAD;
      cyc();
      exp_d = q.pop_front();
      vec++; if (level !== 4'd7 || overflow !== 1'b1 || data_out !== exp_d || wr_ack !== 1'b0) begin
         errs++; $display("FAIL simul_full: got level=%0d ovf=%b data=%h ack=%b want 7/1/%h/0", level, overflow, data_out, wr_ack, exp_d);
      end
      wr_en = 1'b0;
      for (int i = 0; i < 7; i++) begin
         cyc();
         exp_d = q.pop_front();
         vec++; if (data_out !== exp_d) begin errs++; $display("FAIL simul_drain_%0d: got %h want %h", i, data_out, exp_d); end
      end
      wr_en = 1'b1; data_in = 16'h3C3C; q.push_back(data_in);
      cyc();
      vec++; if (level !== 4'd1 || underflow !== 1'b1 || wr_ack !== 1'b1) begin
         errs++; $display("FAIL simul_empty: got level=%0d udf=%b ack=%b want 1/1/1", level, underflow, wr_ack);
      end
      wr_en = 1'b0;
      cyc();
      exp_d = q.pop_front();
      vec++; if (data_out !== exp_d || empty !== 1'b1) begin
         errs++; $display("FAIL simul_readback: got %h empty=%b want %h/1", data_out, empty, exp_d);
      end
      rd_en = 1'b0; err_clr = 1'b1;
      cyc();
      err_clr = 1'b0;
   endtask

   task automatic test_thresholds();
      af_thresh = 4'd6; ae_thresh = 4'd2;
      #1;
      for (int l = 0; l <= 8; l++) begin
         vec++; if (almostempty !== (l <= 2) || almostfull !== (l >= 6) || level !== 4'(l)) begin
            errs++; $display("FAIL thresh_lvl%0d: got ae=%b af=%b level=%0d want %b/%b/%0d", l, almostempty, almostfull, level, (l <= 2), (l >= 6), l);
         end
         if (l < 8) begin
            wr_en = 1'b1; data_in = 16'(16'h4000 + l); q.push_back(data_in);
            cyc();
            wr_en = 1'b0;
         end
      end
      for (int i = 0; i < 4; i++) begin
         rd_en = 1'b1;
         cyc();
         exp_d = q.pop_front();
         vec++; if (data_out !== exp_d) begin errs++; $display("FAIL thresh_read_%0d: got %h want %h", i, data_out, exp_d); end
      end
      rd_en = 1'b0;
      vec++; if (almostfull !== 1'b0) begin errs++; $display("FAIL thresh_af6_lvl4: got %b want 0", almostfull); end
      af_thresh = 4'd3;
      #1;
      vec++; if (almostfull !== 1'b1) begin errs++; $display("FAIL thresh_af3_lvl4: got %b want 1", almostfull); end
      for (int i = 0; i < 4; i++) begin
         rd_en = 1'b1;
         cyc();
         exp_d = q.pop_front();
         vec++; if (data_out !== exp_d) begin errs++; $display("FAIL thresh_drain_%0d: got %h want %h", i, data_out, exp_d); end
      end
      rd_en = 1'b0; af_thresh = 4'd8; ae_thresh = 4'd0;
      cyc();
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 5; i++) begin
         wr_en = 1'b1; data_in = 16'(16'h5000 + i);
         cyc();
      end
      vec++; if (level !== 4'd5) begin errs++; $display("FAIL areset_pre: got level=%0d want 5", level); end
      rd_en = 1'b1; data_in = 16'h5555;
      cyc();
      #2;
      rst_n = 1'b0;
      #1;
      vec++; if ({full, empty, almostfull, almostempty, wr_ack, overflow, underflow, ovf_sticky, udf_sticky} !== 9'b0 || level !== 4'd0 || data_out !== 16'h0) begin
         errs++; $display("FAIL areset_mid: got flags=%b level=%0d data=%h want 0/0/0000", {full, empty, almostfull, almostempty, wr_ack, overflow, underflow, ovf_sticky, udf_sticky}, level, data_out);
      end
      wr_en = 1'b0; rd_en = 1'b0;
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      cyc();
      vec++; if (empty !== 1'b1 || level !== 4'd0 || wr_ack !== 1'b0) begin
         errs++; $display("FAIL areset_post: got empty=%b level=%0d ack=%b want 1/0/0", empty, level, wr_ack);
      end
      wr_en = 1'b1; data_in = 16'hBEEF; q.push_back(data_in);
      cyc();
      wr_en = 1'b0; rd_en = 1'b1;
      cyc();
      rd_en = 1'b0;
      exp_d = q.pop_front();
      vec++; if (data_out !== exp_d || empty !== 1'b1) begin
         errs++; $display("FAIL areset_newdata: got %h empty=%b want %h/1", data_out, empty, exp_d);
      end
   endtask

   task automatic test_fwft();
      int n;
      f_wr_en = 1'b1; f_data_in = 16'hA5A5;
      cyc();
      f_wr_en = 1'b0;
      vec++; if (f_data_out !== 16'hA5A5 || f_empty !== 1'b0) begin
         errs++; $display("FAIL fwft_first: got %h empty=%b want a5a5/0", f_data_out, f_empty);
      end
      f_rd_en = 1'b1;
      cyc();
      f_rd_en = 1'b0;
      vec++; if (f_empty !== 1'b1 || f_underflow !== 1'b0) begin
         errs++; $display("FAIL fwft_pop: got empty=%b udf=%b want 1/0", f_empty, f_underflow);
      end
      for (int i = 0; i < 12; i++) begin
         f_wr_en = 1'b1; f_data_in = 16'(16'hB000 + i);
         f_rd_en = (fq.size() > 0) && (i % 4 != 3);
         if (fq.size() > 0) begin
            vec++; if (f_data_out !== fq[0]) begin errs++; $display("FAIL fwft_head_%0d: got %h want %h", i, f_data_out, fq[0]); end
         end
         if (f_rd_en) exp_d = fq.pop_front();
         fq.push_back(f_data_in);
         cyc();
         vec++; if (f_level !== 4'(fq.size()) || f_wr_ack !== 1'b1) begin
            errs++; $display("FAIL fwft_level_%0d: got %0d ack=%b want %0d/1", i, f_level, f_wr_ack, fq.size());
         end
      end
      f_wr_en = 1'b0;
      n = fq.size();
      for (int i = 0; i < n; i++) begin
         exp_d = fq.pop_front();
         vec++; if (f_data_out !== exp_d) begin errs++; $display("FAIL fwft_drain_%0d: got %h want %h", i, f_data_out, exp_d); end
         f_rd_en = 1'b1;
         cyc();
      end
      f_rd_en = 1'b0;
      vec++; if (f_empty !== 1'b1 || f_level !== 4'd0) begin
         errs++; $display("FAIL fwft_end: got empty=%b level=%0d want 1/0", f_empty, f_level);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
      data_in = 16'h0; af_thresh = 4'd8; ae_thresh = 4'd0;
      f_wr_en = 1'b0; f_rd_en = 1'b0; f_err_clr = 1'b0;
      f_data_in = 16'h0; f_af_thresh = 4'd5; f_ae_thresh = 4'd0;
      test_reset();
      test_fill_drain();
      test_ovf_udf();
      test_simultaneous();
      test_thresholds();
      test_fwft();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sync_fifo_prog.md
Name: sync_fifo_prog

Overview:
Next-generation single-clock FIFO that supersedes the fixed 16x8 FIFO.
- Generalised width and depth; depth need not be a power of two.
- Selectable standard (registered-read) or first-word-fall-through (FWFT) output mode.
- Run-time programmable almost-full/almost-empty thresholds, a live occupancy output, and sticky error flags with clear.
- Sits between the stimulus/packet producers and consumers in the datapath, as a drop-in buffer.

Parameters:
FIFO_WIDTH, 16, data word width in bits (>=1)
FIFO_DEPTH, 8, number of entries (>=2, any integer)
FWFT, 0, 0 = standard mode (data on data_out one cycle after rd_en); 1 = head word visible on data_out whenever !empty
AW, $clog2(FIFO_DEPTH), derived localparam, pointer width; level/threshold width is AW+1

Ports:
clk  in  1  single clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write request
data_in  in  FIFO_WIDTH  write data
rd_en  in  1  read (pop) request
af_thresh  in  AW+1  almostfull asserted when level >= af_thresh
ae_thresh  in  AW+1  almostempty asserted when level <= ae_thresh
err_clr  in  1  clears sticky error flags
data_out  out  FIFO_WIDTH  read data
wr_ack  out  1  registered: previous-cycle write accepted
overflow  out  1  registered: previous-cycle write rejected
underflow  out  1  registered: previous-cycle read rejected
full  out  1  level == FIFO_DEPTH
empty  out  1  level == 0
almostfull  out  1  level >= af_thresh
almostempty  out  1  level <= ae_thresh
level  out  AW+1  current occupancy 0..FIFO_DEPTH
ovf_sticky  out  1  latched overflow
udf_sticky  out  1  latched underflow

Behaviour:
- Reset (rst_n low, async):
  - wr_ptr, rd_ptr, level <= 0.
  - data_out, wr_ack, overflow, underflow, ovf_sticky, udf_sticky <= 0.
  - full, empty, almostfull, almostempty forced 0 while rst_n is low.
  - First clk after release: empty=1, and almostempty=1 if ae_thresh>=0.
  - Memory contents are not reset.
- Accept rules, evaluated on pre-edge level:
  - wr_acc = wr_en && level<FIFO_DEPTH.
  - rd_acc = rd_en && level>0.
  - Full + wr_en + rd_en: read accepted, write rejected, level-1.
  - Empty + wr_en + rd_en: write accepted, read rejected, level+1.
  - Otherwise both accepted, level unchanged.
- Update: level_next = level + wr_acc - rd_acc.
- Pointers: increment on acceptance; wrap from FIFO_DEPTH-1 to 0 explicitly (non-power-of-two safe).
- Status flags: full/empty/almostfull/almostempty are combinational from the level register and threshold inputs. Threshold compares are unsigned, AW+1 bits. af_thresh=0 means almostfull is always 1. Threshold changes take effect immediately.
- Handshake outputs, registered one cycle after the request edge:
  - wr_ack <= wr_acc
  - overflow <= wr_en && !wr_acc
  - underflow <= rd_en && !rd_acc
  - These pulse for exactly the cycles of the cause.
- Sticky errors: ovf_sticky is set on (wr_en && !wr_acc) and cleared by err_clr. Set wins over clear in the same cycle. udf_sticky likewise.
- Standard mode: on rd_acc, data_out <= mem[rd_ptr]; 1-cycle latency. data_out holds its value otherwise, including on underflow.
- FWFT mode:
  - data_out = mem[rd_ptr] (combinational read); valid when !empty.
  - rd_acc pops; the next word appears the same cycle the pointer moves.
  - Write into an empty FIFO is visible on data_out the cycle after the write edge.
  - Content of data_out is don't-care while empty.
- Simultaneous read/write on the same address (level==0 or wrap collision): no read-during-write bypass. Empty-case read is rejected, so no hazard arises.
- Reset mid-operation: all state clears asynchronously. In-flight wr_ack/overflow/underflow pulses are dropped.

Decomposition:
- Package fifo_pkg:
  - typedef enum {FIFO_STD, FIFO_FWFT} fifo_mode_e
  - function ptr_inc(ptr, depth) implementing the wrap
  - localparam helpers for AW
- Sub-module fifo_mem: FIFO_DEPTH x FIFO_WIDTH array, synchronous write port, asynchronous read port.
- sync_fifo_prog holds pointers, level, flags, handshake and output-mode logic.

Test Plan (FIFO_WIDTH=16, FIFO_DEPTH=8 unless noted):
- Fill/drain std mode: write 0x1000..0x1007, then 8 reads -> wr_ack 8 pulses, full=1 at level 8, data_out 0x1000..0x1007 each one cycle after rd_en, empty=1 at end.
- Overflow/underflow: write 9 words, then read 9 -> overflow pulses once on the 9th write cycle +1, underflow once; ovf_sticky/udf_sticky stay 1 until err_clr, then 0.
- Simultaneous at boundaries: at level 8, wr_en&rd_en -> level 7, overflow=1, read data correct; at level 0, wr_en&rd_en -> level 1, underflow=1.
- Thresholds: af_thresh=6, ae_thresh=2; step level 0..8 -> almostempty=1 for 0..2, almostfull=1 for 6..8; change af_thresh to 3 at level 4 -> almostfull=1 same cycle.
- FWFT, FIFO_DEPTH=5: write 0xA5A5 to empty -> data_out=0xA5A5 next cycle without rd_en; 12 interleaved writes/reads -> pointers wrap at 4->0, data order preserved.
- Async reset mid-burst at level 5 -> all outputs 0 immediately; after release empty=1, level=0, and next write/read returns new data only.
